// File: rtl/sipo_write_ctrl_if.sv
// Bus between the row-write controller and its neighbours: host command, serial
// bit stream, SIPO control and the array word-line/ack handshake.
interface sipo_write_ctrl_if #(
  parameter int ROWS = 16
);
  localparam int AW = $clog2(ROWS);

  logic          start;
  logic [AW-1:0] row_addr;
  logic          abort;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic          sipo_shift;
  logic          sipo_serial;
  logic          sipo_load;
  logic          wl_en;
  logic [AW-1:0] row_addr_q;
  logic          array_ack;
  logic          busy;
  logic          done;
  logic          err;

  // master = controller
  modport master (
    input  start, row_addr, abort, bit_in, bit_valid, array_ack,
    output bit_ready, sipo_shift, sipo_serial, sipo_load, wl_en, row_addr_q,
           busy, done, err
  );

  modport slave (
    output start, row_addr, abort, bit_in, bit_valid, array_ack,
    input  bit_ready, sipo_shift, sipo_serial, sipo_load, wl_en, row_addr_q,
           busy, done, err
  );
endinterface

// File: rtl/sipo_write_ctrl.sv
// Row-write sequencer: shifts COLS serial bits into the SIPO, loads it, pulses the
// word line for WL_PULSE cycles, then waits (bounded) for the array write ack.
module sipo_write_ctrl #(
  parameter int COLS        = 8,
  parameter int ROWS        = 16,
  parameter int WL_PULSE    = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             arst_n,
  sipo_write_ctrl_if.master bus
);
  localparam int AW = $clog2(ROWS);
  localparam int BW = $clog2(COLS + 1);
  localparam int WW = $clog2(WL_PULSE + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(COLS - 1);
  localparam logic [WW-1:0] WL_LAST  = WW'(WL_PULSE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_LOAD, S_WRITE, S_WAIT_ACK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WW-1:0] wl_cnt_q, wl_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;

  logic ready, shift, serial, load, wl, done;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      wl_cnt_q  <= '0;
      to_cnt_q  <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wl_cnt_q  <= wl_cnt_d;
      to_cnt_q  <= to_cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wl_cnt_d  = wl_cnt_q;
    to_cnt_d  = to_cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    ready     = 1'b0;
    shift     = 1'b0;
    serial    = 1'b0;
    load      = 1'b0;
    wl        = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d   = S_SHIFT;
          addr_d    = bus.row_addr;
          bit_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      S_SHIFT: begin
        ready  = 1'b1;
        serial = bus.bit_in;
        shift  = bus.bit_valid;
        if (bus.bit_valid) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load     = 1'b1;
        state_d  = S_WRITE;
        wl_cnt_d = '0;
      end
      S_WRITE: begin
        wl       = 1'b1;
        wl_cnt_d = wl_cnt_q + 1'b1;
        if (wl_cnt_q == WL_LAST) begin
          state_d  = S_WAIT_ACK;
          to_cnt_d = '0;
        end
      end
      S_WAIT_ACK: begin
        if (bus.array_ack) begin
          state_d = S_DONE;
          err_d   = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything in flight; err keeps its previous completion value.
    if (bus.abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      wl_cnt_d  = '0;
      to_cnt_d  = '0;
      err_d     = err_q;
      ready     = 1'b0;
      shift     = 1'b0;
      serial    = 1'b0;
      load      = 1'b0;
      wl        = 1'b0;
      done      = 1'b0;
    end
  end

  assign bus.bit_ready   = ready;
  assign bus.sipo_shift  = shift;
  assign bus.sipo_serial = serial;
  assign bus.sipo_load   = load;
  assign bus.wl_en       = wl;
  assign bus.row_addr_q  = addr_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_sipo_write_ctrl.sv
// Directed bench for sipo_write_ctrl with a behavioural SIPO (shift has priority).
module tb_sipo_write_ctrl;
  localparam int COLS = 8, ROWS = 16, WL = 2, TO = 15;

  logic clk = 1'b0, arst_n = 1'b0;
  always #5 clk = ~clk;

  sipo_write_ctrl_if #(.ROWS(ROWS)) bus();
  sipo_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .WL_PULSE(WL), .ACK_TIMEOUT(TO))
    dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  logic [COLS-1:0] sh_q, par_q;
  always @(posedge clk) begin
    if (bus.sipo_shift)     sh_q  <= {sh_q[COLS-2:0], bus.sipo_serial};
    else if (bus.sipo_load) par_q <= sh_q;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int n_shift, n_load, n_wl, first_wl, last_wl, load_cyc, done_cyc, n_done, overlap;
  logic done_err, rst_wl, rst_busy, ab_busy, end_busy, end_err;
  logic [3:0] rq_done;

  task automatic run(input int row, input logic [7:0] data, input int stall_from,
                     input int stall_len, input int ack_at, input int abort_at,
                     input int rst_at, input bit noise);
    int sent;
    bit fin;
    n_shift = 0; n_load = 0; n_wl = 0; first_wl = -1; last_wl = -1;
    load_cyc = -1; done_cyc = -1; n_done = 0; overlap = 0;
    done_err = 1'bx; rq_done = 'x; rst_wl = 1'bx; rst_busy = 1'bx; ab_busy = 1'bx;
    sent = 0; fin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.row_addr = 4'(row);
    for (int rc = 1; rc < 80 && !fin; rc++) begin
      @(posedge clk); #1;
      bus.start     = noise;
      bus.row_addr  = noise ? 4'd9 : 4'(row);
      bus.abort     = (rc == abort_at);
      bus.array_ack = (rc == ack_at) || (noise && rc == 3);
      bus.bit_valid = (sent < COLS) && !(rc >= stall_from && rc < stall_from + stall_len);
      bus.bit_in    = (sent < COLS) ? data[COLS-1-sent] : 1'b0;
      if (rc == rst_at) arst_n = 1'b0;
      @(negedge clk);
      if (bus.bit_valid && bus.bit_ready) sent++;
      if (bus.sipo_shift) n_shift++;
      if (bus.sipo_load) begin n_load++; load_cyc = rc; end
      if (bus.sipo_shift && bus.sipo_load) overlap++;
      if (bus.wl_en) begin
        n_wl++;
        if (first_wl < 0) first_wl = rc;
        last_wl = rc;
      end
      if (bus.done) begin
        n_done++; done_cyc = rc; done_err = bus.err; rq_done = bus.row_addr_q; fin = 1'b1;
      end
      if (rc == rst_at) begin rst_wl = bus.wl_en; rst_busy = bus.busy; fin = 1'b1; end
      if (abort_at > 0 && rc == abort_at + 1) begin ab_busy = bus.busy; fin = 1'b1; end
    end
    if (!fin) $display("FAIL timeout: run for row %0d never finished", row);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.array_ack = 1'b0; bus.bit_valid = 1'b0;
    arst_n = 1'b1;
    @(negedge clk);
    end_busy = bus.busy; end_err = bus.err;
  endtask

  initial begin
    bus.start = 1'b0; bus.row_addr = '0; bus.abort = 1'b0; bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0; bus.array_ack = 1'b0;
    #3;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ctl", {bus.bit_ready, bus.sipo_shift, bus.sipo_load, bus.wl_en, bus.done}, 5'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_row", bus.row_addr_q, 4'd0);
    @(negedge clk); arst_n = 1'b1;

    // nominal
    run(3, 8'hA5, 99, 0, 12, -1, -1, 1'b0);
    chk("t1_shifts", n_shift, 8);   chk("t1_load_cyc", load_cyc, 9);
    chk("t1_nload", n_load, 1);     chk("t1_wl_first", first_wl, 10);
    chk("t1_wl_last", last_wl, 11); chk("t1_done_cyc", done_cyc, 13);
    chk("t1_err", done_err, 1'b0);  chk("t1_par", par_q, 8'hA5);
    chk("t1_row", rq_done, 4'd3);   chk("t1_idle", end_busy, 1'b0);
    chk("t1_overlap", overlap, 0);

    // stalled stream
    run(5, 8'h3C, 3, 3, 15, -1, -1, 1'b0);
    chk("t2_shifts", n_shift, 8);   chk("t2_load_cyc", load_cyc, 12);
    chk("t2_par", par_q, 8'h3C);    chk("t2_done_cyc", done_cyc, 16);

    // ack timeout
    run(7, 8'hFF, 99, 0, -1, -1, -1, 1'b0);
    chk("t3_done_cyc", done_cyc, 27); chk("t3_err", done_err, 1'b1);
    chk("t3_idle", end_busy, 1'b0);   chk("t3_err_held", end_err, 1'b1);
    chk("t3_nwl", n_wl, 2);

    // abort after 4 shifts
    run(2, 8'h0F, 99, 0, -1, 5, -1, 1'b0);
    chk("t4_shifts", n_shift, 4);   chk("t4_nload", n_load, 0);
    chk("t4_nwl", n_wl, 0);         chk("t4_ndone", n_done, 0);
    chk("t4_idle", ab_busy, 1'b0);  chk("t4_par", par_q, 8'hFF);
    run(4, 8'h81, 99, 0, 12, -1, -1, 1'b0);
    chk("t4b_done_cyc", done_cyc, 13); chk("t4b_err", done_err, 1'b0);
    chk("t4b_par", par_q, 8'h81);

    // start/ack noise ignored
    run(3, 8'h66, 99, 0, 12, -1, -1, 1'b1);
    chk("t5_row", rq_done, 4'd3);      chk("t5_done_cyc", done_cyc, 13);
    chk("t5_load_cyc", load_cyc, 9);   chk("t5_ndone", n_done, 1);
    chk("t5_idle", end_busy, 1'b0);    chk("t5_par", par_q, 8'h66);

    // reset mid-WRITE
    run(6, 8'hAA, 99, 0, -1, -1, 10, 1'b0);
    chk("t6_wl", rst_wl, 1'b0);     chk("t6_busy", rst_busy, 1'b0);
    chk("t6_nload", n_load, 1);     chk("t6_row_rst", bus.row_addr_q, 4'd0);
    run(1, 8'hC3, 99, 0, 12, -1, -1, 1'b0);
    chk("t6b_shifts", n_shift, 8);  chk("t6b_par", par_q, 8'hC3);
    chk("t6b_done_cyc", done_cyc, 13);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
